// File: rtl/cory_pix_unpack2d_if.sv
// Bus bundle for the 2D pixel unpacker: frame command, DMA word stream and pixel stream.
// The slave modport is the unpacker's view. The master modport is the surrounding system's view.
interface cory_pix_unpack2d_if #(
  parameter int D = 64,
  parameter int P = 8,
  parameter int R = 11
);
  logic         i_cmd_v;
  logic [R-1:0] i_cmd_width;
  logic [R-1:0] i_cmd_height;
  logic         o_cmd_r;

  logic         i_din_v;
  logic [D-1:0] i_din_d;
  logic         o_din_r;

  logic         o_pix_v;
  logic [P-1:0] o_pix_d;
  logic         i_pix_r;
  logic         o_pix_sol;
  logic         o_pix_eol;
  logic         o_pix_sof;
  logic         o_pix_eof;

  logic         o_busy;

  modport slave (
    input  i_cmd_v, i_cmd_width, i_cmd_height,
    output o_cmd_r,
    input  i_din_v, i_din_d,
    output o_din_r,
    output o_pix_v, o_pix_d, o_pix_sol, o_pix_eol, o_pix_sof, o_pix_eof,
    input  i_pix_r,
    output o_busy
  );

  modport master (
    output i_cmd_v, i_cmd_width, i_cmd_height,
    input  o_cmd_r,
    output i_din_v, i_din_d,
    input  o_din_r,
    input  o_pix_v, o_pix_d, o_pix_sol, o_pix_eol, o_pix_sof, o_pix_eof,
    output i_pix_r,
    input  o_busy
  );
endinterface

// File: rtl/cory_pix_unpack2d.sv
// Unpacks D-bit DMA words into a P-bit pixel stream for a width x height frame.
// Each pixel carries line and frame markers. Any pad pixels at the end of a line are dropped.
module cory_pix_unpack2d #(
  parameter int D = 64,
  parameter int P = 8,
  parameter int R = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  cory_pix_unpack2d_if.slave bus
);

  localparam int N  = D / P;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic           cmd_v_q;
  logic [R-1:0]   width_q, height_q;
  logic [R-1:0]   x_q, y_q;
  logic [KW-1:0]  k_q;
  logic [D-1:0]   hold_q;
  logic           hold_v_q;

  logic start;
  logic pix_hs;
  logic din_hs;
  logic eol;
  logic eof;
  logic word_end;
  logic din_r;

  // A start is a fresh rising edge of the command. Edges seen in RUN or DONE are ignored.
  assign start    = bus.i_cmd_v & ~cmd_v_q & (state_q == S_IDLE);
  assign pix_hs   = hold_v_q & bus.i_pix_r;
  assign eol      = (x_q == width_q - R'(1));
  assign eof      = eol & (y_q == height_q - R'(1));
  assign word_end = (k_q == KW'(N - 1)) | eol;
  assign din_hs   = din_r & bus.i_din_v;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    din_r   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((bus.i_cmd_width != '0) && (bus.i_cmd_height != '0)) state_d = S_RUN;
          else                                                     state_d = S_DONE;
        end
      end
      S_RUN: begin
        // Refill as the last pixel of the word leaves, so the stream has no bubble.
        // The word after the frame's eof pixel belongs to the next frame, so it is never taken here.
        din_r = ~hold_v_q | (pix_hs & word_end & ~eof);
        if (pix_hs && eof) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // This flop resets high. A command that is already high at reset release must first be seen low.
      cmd_v_q  <= 1'b1;
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      cmd_v_q <= bus.i_cmd_v;
      if (start) begin
        width_q  <= bus.i_cmd_width;
        height_q <= bus.i_cmd_height;
        x_q      <= '0;
        y_q      <= '0;
        k_q      <= '0;
        hold_v_q <= 1'b0;
      end else if (state_q == S_RUN) begin
        if (din_hs) begin
          hold_q   <= bus.i_din_d;
          hold_v_q <= 1'b1;
        end else if (pix_hs && word_end) begin
          hold_v_q <= 1'b0;
        end
        if (pix_hs) begin
          k_q <= word_end ? '0 : k_q + KW'(1);
          x_q <= eol ? '0 : x_q + R'(1);
          if (eol) y_q <= eof ? '0 : y_q + R'(1);
        end
      end else begin
        hold_v_q <= 1'b0;
      end
    end
  end

  assign bus.o_din_r   = din_r;
  assign bus.o_cmd_r   = (state_q == S_DONE);
  assign bus.o_busy    = (state_q == S_RUN);
  assign bus.o_pix_v   = hold_v_q;
  assign bus.o_pix_d   = hold_q[k_q*P +: P];
  assign bus.o_pix_sol = hold_v_q & (x_q == '0);
  assign bus.o_pix_eol = hold_v_q & eol;
  assign bus.o_pix_sof = hold_v_q & (x_q == '0) & (y_q == '0);
  assign bus.o_pix_eof = hold_v_q & eof;

endmodule

// File: tb/tb_cory_pix_unpack2d.sv
// Self-checking bench for cory_pix_unpack2d: a table of frames plus random frames, checked against a list-of-pixels model.
// Also covers a mid-frame reset and a command that is already high at reset release.
module tb_cory_pix_unpack2d;
  localparam int D = 64;
  localparam int P = 8;
  localparam int R = 11;
  localparam int N = D / P;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cory_pix_unpack2d_if #(.D(D), .P(P), .R(R)) bus ();
  cory_pix_unpack2d #(.D(D), .P(P), .R(R)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [P-1:0] d;
    bit sol, eol, sof, eof, last;
  } pix_t;

  typedef struct {
    string name;
    int    w, h, rmode, vmode;
    bit    fixed;
    int    exp_pix, exp_words;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rmode selects the sink: 0 = always ready, 1 = toggles each cycle, 2 = random.
  // vmode selects the DMA: 0 = always valid, 1 = random gaps.
  task automatic run_frame(input string name, input int w, input int h, input int rmode,
                           input int vmode, input bit fixed, input int abort_after,
                           input int exp_pix, input int exp_words);
    pix_t         exp_q[$];
    logic [D-1:0] words[$];
    logic [D-1:0] junk, wd, pat;
    pix_t         e;
    int wpl, x, got, taken, cyc, first_cyc, eof_cyc, cmdr_cyc, cmdr_cnt, din_bad, busy_bad, total;
    bit eof_done, prev_stall, pr, run_m;
    logic [P+3:0] prev_out, cur_out;

    junk = 64'hDEAD_BEEF_0BAD_F00D;
    pat  = 64'h0706_0504_0302_0100;
    wpl  = (w + N - 1) / N;
    if (w > 0 && h > 0) begin
      for (int y = 0; y < h; y++) begin
        for (int wi = 0; wi < wpl; wi++) begin
          wd = fixed ? pat : {$urandom, $urandom};
          words.push_back(wd);
          for (int k = 0; k < N; k++) begin
            x = wi * N + k;
            if (x < w) begin
              e.d    = wd[k*P +: P];
              e.sol  = (x == 0);
              e.eol  = (x == w - 1);
              e.sof  = (x == 0) && (y == 0);
              e.eof  = (x == w - 1) && (y == h - 1);
              e.last = (k == N - 1) || (x == w - 1);
              exp_q.push_back(e);
            end
          end
        end
      end
    end
    total = exp_q.size();

    bus.i_cmd_v = 1'b0;
    bus.i_din_v = 1'b0;
    bus.i_pix_r = 1'b0;
    @(posedge clk);
    got = 0; taken = 0; cyc = 0; first_cyc = -1; eof_cyc = -1; cmdr_cyc = -1; cmdr_cnt = 0;
    din_bad = 0; busy_bad = 0; eof_done = 0; prev_stall = 0; prev_out = '0;

    while (cyc < 3000) begin
      @(negedge clk);
      bus.i_cmd_v      = (cmdr_cnt == 0);
      bus.i_cmd_width  = R'(w);
      bus.i_cmd_height = R'(h);
      case (rmode)
        0:       pr = 1'b1;
        1:       pr = (cyc % 2 == 0);
        default: pr = 1'($urandom_range(0, 1));
      endcase
      bus.i_pix_r = pr;
      // Once the frame's words are used up, junk stays offered so any extra consumption shows up.
      if (taken < words.size()) begin
        bus.i_din_v = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.i_din_d = words[taken];
      end else begin
        bus.i_din_v = 1'b1;
        bus.i_din_d = junk;
      end
      #1;
      cur_out = {bus.o_pix_d, bus.o_pix_sol, bus.o_pix_eol, bus.o_pix_sof, bus.o_pix_eof};
      run_m   = (cyc >= 1) && !eof_done && (total > 0);
      if (prev_stall) check({name, " stall_hold"}, {bus.o_pix_v, cur_out}, {1'b1, prev_out});
      if (bus.o_busy !== run_m) busy_bad++;
      if (bus.o_din_r && !run_m) din_bad++;
      if (bus.o_din_r && bus.o_pix_v && exp_q.size() > 0 &&
          !(pr && exp_q[0].last && !exp_q[0].eof)) din_bad++;
      if (bus.o_pix_v && pr) begin
        if (exp_q.size() == 0) begin
          check({name, " pix_overrun"}, got + 1, total);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s pix%0d", name, got), cur_out, {e.d, e.sol, e.eol, e.sof, e.eof});
          if (got == 0) first_cyc = cyc;
          if (e.eof) begin
            eof_cyc  = cyc;
            eof_done = 1'b1;
          end
        end
        got++;
      end
      if (bus.o_din_r && bus.i_din_v) taken++;
      if (bus.o_cmd_r) begin
        if (cmdr_cnt == 0) cmdr_cyc = cyc;
        cmdr_cnt++;
      end
      prev_stall = bus.o_pix_v && !pr;
      prev_out   = cur_out;
      cyc++;
      if (abort_after >= 0 && got == abort_after) break;
      if (cmdr_cnt > 0 && cyc > cmdr_cyc + 3) break;
    end

    if (abort_after >= 0) begin
      check({name, " reached_abort"}, got, abort_after);
      return;
    end
    check({name, " pixels"}, got, exp_pix);
    check({name, " words"}, taken, exp_words);
    check({name, " cmd_r_pulses"}, cmdr_cnt, 1);
    check({name, " busy_rule"}, busy_bad, 0);
    check({name, " din_r_rule"}, din_bad, 0);
    if (exp_pix > 0) check({name, " cmd_r_after_eof"}, cmdr_cyc, eof_cyc + 1);
    else             check({name, " cmd_r_empty"}, cmdr_cyc, 1);
    if (rmode == 0 && vmode == 0 && exp_pix > 0)
      check({name, " no_bubble"}, eof_cyc - first_cyc, exp_pix - 1);
  endtask

  vec_t vecs[8];

  initial begin
    int bad;
    int w, h;
    vecs[0] = '{"f16x2",     16, 2, 0, 0, 1'b0, 32, 4};
    vecs[1] = '{"f5x3",       5, 3, 0, 0, 1'b1, 15, 3};
    vecs[2] = '{"f16x1_tog", 16, 1, 1, 0, 1'b0, 16, 2};
    vecs[3] = '{"f0x4",       0, 4, 0, 0, 1'b0,  0, 0};
    vecs[4] = '{"f4x0",       4, 0, 0, 0, 1'b0,  0, 0};
    vecs[5] = '{"f1x1",       1, 1, 0, 0, 1'b0,  1, 1};
    vecs[6] = '{"f9x2_rnd",   9, 2, 2, 1, 1'b0, 18, 4};
    vecs[7] = '{"f8x3_gap",   8, 3, 0, 1, 1'b0, 24, 3};

    bus.i_cmd_v = 1'b0; bus.i_cmd_width = '0; bus.i_cmd_height = '0;
    bus.i_din_v = 1'b0; bus.i_din_d = '0; bus.i_pix_r = 1'b0;
    #1;
    check("reset_outputs", {bus.o_pix_v, bus.o_din_r, bus.o_cmd_r, bus.o_busy, bus.o_pix_sol,
                            bus.o_pix_eol, bus.o_pix_sof, bus.o_pix_eof, bus.o_pix_d}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i])
      run_frame(vecs[i].name, vecs[i].w, vecs[i].h, vecs[i].rmode, vecs[i].vmode,
                vecs[i].fixed, -1, vecs[i].exp_pix, vecs[i].exp_words);

    for (int i = 0; i < 10; i++) begin
      w = $urandom_range(1, 40);
      h = $urandom_range(1, 3);
      run_frame($sformatf("rnd%0d", i), w, h, 2, 1, 1'b0, -1, w * h, ((w + N - 1) / N) * h);
    end

    // Reset 10 pixels into a frame. The frame is abandoned, and the command that is still high must not restart it.
    run_frame("abort", 16, 2, 0, 0, 1'b0, 10, 32, 4);
    reset_n = 1'b0;
    #1;
    check("midframe_reset", {bus.o_pix_v, bus.o_din_r, bus.o_cmd_r, bus.o_busy, bus.o_pix_sol,
                             bus.o_pix_eol, bus.o_pix_sof, bus.o_pix_eof, bus.o_pix_d}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (bus.o_busy || bus.o_din_r || bus.o_pix_v || bus.o_cmd_r) bad++;
    end
    check("no_start_on_held_cmd", bad, 0);
    run_frame("after_reset", 16, 2, 0, 0, 1'b0, -1, 32, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cory_pix_unpack2d.md
CORY_PIX_UNPACK2D -- requirements
Module: cory_pix_unpack2d

Interface
REQ-001 SHALL have parameter D, default 64, input data word width in bits.
REQ-002 SHALL have parameter P, default 8, pixel width in bits; D SHALL be an integer multiple of P; N = D/P pixels per word.
REQ-003 SHALL have parameter R, default 11, bit width of resolution fields.
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_cmd_v, input, 1, frame command valid, held high until o_cmd_r.
REQ-007 SHALL have port i_cmd_width, input, R, line width in pixels.
REQ-008 SHALL have port i_cmd_height, input, R, frame height in lines.
REQ-009 SHALL have port o_cmd_r, input-acknowledge output, 1, one-cycle pulse at frame completion.
REQ-010 SHALL have ports i_din_v (in, 1), i_din_d (in, D), o_din_r (out, 1): word stream from the 2D read DMA.
REQ-011 SHALL have ports o_pix_v (out, 1), o_pix_d (out, P), i_pix_r (in, 1): pixel stream.
REQ-012 SHALL have outputs o_pix_sol, o_pix_eol, o_pix_sof, o_pix_eof, 1 bit each, qualified by o_pix_v.
REQ-013 SHALL have output o_busy, 1, high in RUN state.

Function
REQ-014 Frame start SHALL be the rising edge of i_cmd_v (one-cycle detect); width/height SHALL be sampled then into internal registers.
REQ-015 States: IDLE, RUN, DONE. IDLE->RUN on start when width!=0 and height!=0; IDLE->DONE on start when either is 0; RUN->DONE on handshake of the eof pixel; DONE->IDLE unconditionally next cycle.
REQ-016 o_cmd_r SHALL be 1 exactly in DONE; 0 otherwise.
REQ-017 Each line SHALL consume ceil(width/N) input words; pixels beyond width in the last word of a line SHALL be discarded, never output.
REQ-018 Pixel order within a word: pixel k = i_din_d[k*P +: P], k=0 first.
REQ-019 One-word holding register with valid bit; o_pix_v = holding valid; o_pix_d = selected pixel of held word.
REQ-020 o_din_r SHALL be 1 in RUN when holding empty, or when the current pixel is handshaked and is the last of the word (k=N-1 or eol); refill SHALL be back-to-back with zero bubble (1 pixel/cycle sustained).
REQ-021 o_din_r SHALL be 0 in IDLE and DONE; words arriving then SHALL NOT be consumed.
REQ-022 Counters: pixel index k (log2 N bits, wraps to 0 at word end or eol), x (R bits, 0..width-1, clears at eol), y (R bits, 0..height-1).
REQ-023 o_pix_sol = (x==0); o_pix_eol = (x==width-1); o_pix_sof = (x==0 && y==0); o_pix_eof = eol && (y==height-1).
REQ-024 i_pix_r low SHALL stall all counters and hold o_pix_d and flags stable; o_pix_v SHALL not drop once asserted until handshake.
REQ-025 A rising edge of i_cmd_v in RUN or DONE SHALL be ignored.
REQ-026 Width-by-height products SHALL use R-bit compare only; no multiplier.

Reset
REQ-027 On reset_n low: state=IDLE, holding valid=0, k=x=y=0, o_pix_v=0, o_din_r=0, o_cmd_r=0, o_busy=0, all flags 0; asynchronous, mid-frame reset SHALL abandon the frame with no further output.
REQ-028 After reset release, i_cmd_v already high SHALL NOT start a frame until it is seen low then high.

Verification
REQ-029 D=64,P=8, width=16,height=2, 4 words, i_pix_r=1 -> 32 pixels in 32 consecutive cycles after first word, bytes in order 0..7, sol at x=0, eol at x=15, eof on pixel 31, o_cmd_r pulse 1 cycle later.
REQ-030 width=5,height=3, words 0x0706050403020100 per line -> per line pixels 00..04 only, 3 words consumed, bytes 05..07 dropped, eof on 15th pixel.
REQ-031 width=16,height=1, i_pix_r toggling 1/0 each cycle -> identical 16-pixel sequence, o_pix_d stable during stalls, o_din_r never 1 while holding full and not at word end.
REQ-032 width=0,height=4 -> no o_din_r, o_pix_v stays 0, o_cmd_r pulses in the 2nd cycle after i_cmd_v rise.
REQ-033 reset_n low after 10 pixels of width=16,height=2 frame -> all outputs 0 next edge; new command afterwards produces full correct frame with sof on first pixel.
